// File: rtl/flt_byte_serializer_pkg.sv
// Shared widths, FSM encodings and Adler-32 helpers for flt_byte_serializer.
// The checksum path is built only when ADLER32_EN is defined.
package flt_byte_serializer_pkg;

    localparam int SIZE_W_WD   = 16;
    localparam int SIZE_H_WD   = 16;
    localparam int DATA_PXL_WD = 32;

    localparam logic [15:0] ADLER_MOD = 16'd65521;

    localparam logic [SIZE_W_WD-1:0] W_ZERO = {SIZE_W_WD{1'b0}};
    localparam logic [SIZE_W_WD-1:0] W_ONE  = {{(SIZE_W_WD-1){1'b0}}, 1'b1};
    localparam logic [SIZE_H_WD-1:0] H_ZERO = {SIZE_H_WD{1'b0}};
    localparam logic [SIZE_H_WD-1:0] H_ONE  = {{(SIZE_H_WD-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TYPE  = 3'd1,
        ST_FETCH = 3'd2,
        ST_LOAD  = 3'd3,
        ST_SHIFT = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        FLT_NONE  = 3'd0,
        FLT_SUB   = 3'd1,
        FLT_UP    = 3'd2,
        FLT_AVG   = 3'd3,
        FLT_PAETH = 3'd4
    } flt_typ_t;

    // Both operands are already reduced below the modulus, so a single
    // conditional subtract on a 17-bit sum is enough.
    function automatic logic [15:0] adler_mod_add(input logic [15:0] x, input logic [15:0] y);
        logic [16:0] sum_s;
        logic [16:0] red_s;
        sum_s = {1'b0, x} + {1'b0, y};
        red_s = sum_s - {1'b0, ADLER_MOD};
        if (sum_s >= {1'b0, ADLER_MOD}) begin
            return red_s[15:0];
        end else begin
            return sum_s[15:0];
        end
    endfunction

endpackage

// File: rtl/flt_byte_serializer_adler32_acc.sv
// Running Adler-32 accumulator: folds one byte per valid cycle into a/b.
// init restarts the sums (a=1, b=0) before folding the byte of that cycle.
module adler32_acc
    import flt_byte_serializer_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        init,
    input  logic        val,
    input  logic [7:0]  dat,
    output logic [31:0] adler
);

    logic [15:0] a_r;
    logic [15:0] b_r;
    logic [15:0] a_base_s;
    logic [15:0] b_base_s;
    logic [15:0] a_nxt_s;
    logic [15:0] b_nxt_s;

    // Next a/b for the byte on dat, starting from a fresh seed when init is set.
    always_comb begin
        a_base_s = a_r;
        b_base_s = b_r;
        if (init) begin
            a_base_s = 16'd1;
            b_base_s = 16'd0;
        end else begin
            a_base_s = a_r;
            b_base_s = b_r;
        end
        a_nxt_s = adler_mod_add(a_base_s, {8'h00, dat});
        b_nxt_s = adler_mod_add(b_base_s, a_nxt_s);
    end

    // Checksum state, updated only on accepted bytes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_r <= 16'd1;
            b_r <= 16'd0;
        end else if (val) begin
            a_r <= a_nxt_s;
            b_r <= b_nxt_s;
        end else begin
            a_r <= a_r;
            b_r <= b_r;
        end
    end

    assign adler = {b_r, a_r};

endmodule

// File: rtl/flt_byte_serializer.sv
// Drains one filtered scanline per start/done: filter-type byte, then RGBA words MSB first.
// Define ADLER32_EN to build the Adler-32 accumulator; otherwise adler_o reads 32'h0000_0001.
module flt_byte_serializer
    import flt_byte_serializer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [SIZE_W_WD-1:0]   cfg_w_i,
    input  logic [SIZE_H_WD-1:0]   cfg_h_i,
    input  logic [2:0]             flt_typ_i,
    input  logic                   start_i,
    output logic                   done_o,
    input  logic                   fifo_flt_empty_i,
    output logic                   fifo_flt_rd_o,
    input  logic [DATA_PXL_WD-1:0] fifo_flt_dat_i,
    output logic                   byte_val_o,
    output logic [7:0]             byte_dat_o,
    output logic                   byte_lst_o,
    input  logic                   byte_rdy_i,
    output logic [31:0]            adler_o,
    output logic                   adler_val_o
);

    state_t                 state_r;
    state_t                 state_s;
    logic [SIZE_W_WD-1:0]   cfg_w_r;
    logic [SIZE_H_WD-1:0]   cfg_h_r;
    logic [SIZE_W_WD-1:0]   cnt_pix_r;
    logic [SIZE_W_WD-1:0]   cnt_pix_s;
    logic [SIZE_H_WD-1:0]   line_r;
    logic [1:0]             byte_idx_r;
    logic [1:0]             byte_idx_s;
    logic [DATA_PXL_WD-1:0] shift_r;
    logic [DATA_PXL_WD-1:0] shift_s;
    logic                   byte_val_r;
    logic                   byte_val_s;
    logic [7:0]             byte_dat_r;
    logic [7:0]             byte_dat_s;
    logic                   byte_lst_r;
    logic                   byte_lst_s;
    logic                   done_r;
    logic                   done_s;
    logic                   hs_s;
    logic                   pix_last_s;
    logic                   last_line_s;

    assign hs_s        = byte_val_r && byte_rdy_i;
    assign pix_last_s  = ((cnt_pix_r + W_ONE) == cfg_w_r);
    assign last_line_s = (line_r == (cfg_h_r - H_ONE));

    // Next-state and next-output decode; outputs are registered from these values.
    always_comb begin
        state_s    = state_r;
        cnt_pix_s  = cnt_pix_r;
        byte_idx_s = byte_idx_r;
        shift_s    = shift_r;
        byte_val_s = 1'b0;
        byte_dat_s = byte_dat_r;
        byte_lst_s = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_s    = ST_TYPE;
                    cnt_pix_s  = W_ZERO;
                    byte_val_s = 1'b1;
                    byte_dat_s = {5'b00000, flt_typ_i};
                    // An empty line makes the type byte the last byte of the image.
                    byte_lst_s = (cfg_w_i == W_ZERO) && (line_r == (cfg_h_i - H_ONE));
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_TYPE: begin
                if (hs_s) begin
                    if (cfg_w_r == W_ZERO) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end else begin
                    byte_val_s = 1'b1;
                    byte_lst_s = byte_lst_r;
                end
            end
            ST_FETCH: begin
                if (!fifo_flt_empty_i) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_LOAD: begin
                state_s    = ST_SHIFT;
                shift_s    = fifo_flt_dat_i;
                byte_idx_s = 2'd0;
                byte_val_s = 1'b1;
                byte_dat_s = fifo_flt_dat_i[DATA_PXL_WD-1 -: 8];
            end
            ST_SHIFT: begin
                byte_val_s = 1'b1;
                byte_lst_s = byte_lst_r;
                if (hs_s) begin
                    if (byte_idx_r == 2'd3) begin
                        cnt_pix_s  = cnt_pix_r + W_ONE;
                        byte_val_s = 1'b0;
                        byte_lst_s = 1'b0;
                        if (pix_last_s) begin
                            state_s = ST_DONE;
                            done_s  = 1'b1;
                        end else begin
                            state_s = ST_FETCH;
                        end
                    end else begin
                        byte_idx_s = byte_idx_r + 2'd1;
                        shift_s    = {shift_r[DATA_PXL_WD-9:0], 8'h00};
                        byte_dat_s = shift_r[DATA_PXL_WD-9 -: 8];
                        byte_lst_s = (byte_idx_r == 2'd2) && pix_last_s && last_line_s;
                    end
                end else begin
                    byte_idx_s = byte_idx_r;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM, datapath and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            cnt_pix_r  <= W_ZERO;
            byte_idx_r <= 2'd0;
            shift_r    <= {DATA_PXL_WD{1'b0}};
            byte_val_r <= 1'b0;
            byte_dat_r <= 8'h00;
            byte_lst_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_pix_r  <= cnt_pix_s;
            byte_idx_r <= byte_idx_s;
            shift_r    <= shift_s;
            byte_val_r <= byte_val_s;
            byte_dat_r <= byte_dat_s;
            byte_lst_r <= byte_lst_s;
            done_r     <= done_s;
        end
    end

    // Image geometry is captured once per scanline at start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cfg_w_r <= W_ZERO;
            cfg_h_r <= H_ZERO;
        end else if ((state_r == ST_IDLE) && start_i) begin
            cfg_w_r <= cfg_w_i;
            cfg_h_r <= cfg_h_i;
        end else begin
            cfg_w_r <= cfg_w_r;
            cfg_h_r <= cfg_h_r;
        end
    end

    // Scanline counter wraps to zero after the last line of the image.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            line_r <= H_ZERO;
        end else if (state_r == ST_DONE) begin
            line_r <= last_line_s ? H_ZERO : (line_r + H_ONE);
        end else begin
            line_r <= line_r;
        end
    end

    assign fifo_flt_rd_o = (state_r == ST_FETCH) && !fifo_flt_empty_i;
    assign byte_val_o    = byte_val_r;
    assign byte_dat_o    = byte_dat_r;
    assign byte_lst_o    = byte_lst_r;
    assign done_o        = done_r;

`ifdef ADLER32_EN
    logic        adler_init_s;
    logic        adler_val_r;
    logic [31:0] adler_s;

    // The checksum restarts with the type byte of the first scanline.
    assign adler_init_s = (state_r == ST_TYPE) && hs_s && (line_r == H_ZERO);

    adler32_acc u_adler32_acc (
        .clk   (clk),
        .rstn  (rstn),
        .init  (adler_init_s),
        .val   (hs_s),
        .dat   (byte_dat_r),
        .adler (adler_s)
    );

    // Final-checksum strobe coincides with done of the last scanline.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            adler_val_r <= 1'b0;
        end else begin
            adler_val_r <= done_s && last_line_s;
        end
    end

    assign adler_o     = adler_s;
    assign adler_val_o = adler_val_r;
`else
    assign adler_o     = 32'h0000_0001;
    assign adler_val_o = 1'b0;
`endif

endmodule

// File: tb/tb_flt_byte_serializer.sv
// Self-checking bench for flt_byte_serializer: vector table, FIFO/sink models and a reference byte/Adler model.
module tb_flt_byte_serializer;
    import flt_byte_serializer_pkg::*;

    logic                   clk;
    logic                   rstn;
    logic [SIZE_W_WD-1:0]   cfg_w_i;
    logic [SIZE_H_WD-1:0]   cfg_h_i;
    logic [2:0]             flt_typ_i;
    logic                   start_i;
    logic                   done_o;
    logic                   fifo_flt_empty_i;
    logic                   fifo_flt_rd_o;
    logic [DATA_PXL_WD-1:0] fifo_flt_dat_i;
    logic                   byte_val_o;
    logic [7:0]             byte_dat_o;
    logic                   byte_lst_o;
    logic                   byte_rdy_i;
    logic [31:0]            adler_o;
    logic                   adler_val_o;

    flt_byte_serializer dut (
        .clk              (clk),
        .rstn             (rstn),
        .cfg_w_i          (cfg_w_i),
        .cfg_h_i          (cfg_h_i),
        .flt_typ_i        (flt_typ_i),
        .start_i          (start_i),
        .done_o           (done_o),
        .fifo_flt_empty_i (fifo_flt_empty_i),
        .fifo_flt_rd_o    (fifo_flt_rd_o),
        .fifo_flt_dat_i   (fifo_flt_dat_i),
        .byte_val_o       (byte_val_o),
        .byte_dat_o       (byte_dat_o),
        .byte_lst_o       (byte_lst_o),
        .byte_rdy_i       (byte_rdy_i),
        .adler_o          (adler_o),
        .adler_val_o      (adler_val_o)
    );

    typedef struct {
        int          w;
        int          h;
        int          typ;
        logic [31:0] pix;
        bit          rnd;
        logic [31:0] exp_adler;   // 0 = take the value from the reference model
    } vec_t;

    vec_t        vecs [6];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] fifo_q [$];
    logic [7:0]  cap_q [$];
    bit          cap_lst_q [$];
    logic [7:0]  exp_q [$];
    logic [7:0]  img_q [$];
    bit          rnd_mode = 1'b0;
    bit          load_pend = 1'b0;
    logic [31:0] pend_dat;
    int          cyc = 0;
    int          last_hs_cyc = 0;
    int          rd_empty_viol = 0;
    int          stall_viol = 0;
    int          stray_aval = 0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_dat = 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Adler-32 straight from its definition, over every byte of the current image.
    function automatic logic [31:0] ref_adler();
        int unsigned a;
        int unsigned b;
        logic [31:0] ra;
        logic [31:0] rb;
        a = 1;
        b = 0;
        foreach (img_q[i]) begin
            a = (a + img_q[i]) % 65521;
            b = (b + a) % 65521;
        end
        ra = a;
        rb = b;
        return {rb[15:0], ra[15:0]};
    endfunction

    task automatic chk_reset_vals();
        check("rst_done", done_o, 1'b0);
        check("rst_fifo_rd", fifo_flt_rd_o, 1'b0);
        check("rst_byte_val", byte_val_o, 1'b0);
        check("rst_byte_lst", byte_lst_o, 1'b0);
        check("rst_adler_val", adler_val_o, 1'b0);
        check("rst_byte_dat", byte_dat_o, 8'h00);
        check("rst_adler", adler_o, 32'h0000_0001);
    endtask

    // Input driver: FIFO read data, downstream ready and FIFO empty flag.
    initial begin
        fifo_flt_dat_i   = 32'h0;
        byte_rdy_i       = 1'b1;
        fifo_flt_empty_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (load_pend) begin
                fifo_flt_dat_i = pend_dat;
                load_pend = 1'b0;
            end
            byte_rdy_i = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
            fifo_flt_empty_i = (fifo_q.size() == 0) || (rnd_mode && ($urandom_range(0, 1) == 1));
        end
    end

    // Monitor: FIFO pops, accepted bytes, stall stability and stray strobes.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rstn) begin
                if (fifo_flt_rd_o) begin
                    if (fifo_flt_empty_i) rd_empty_viol++;
                    if (fifo_q.size() > 0) begin
                        pend_dat  = fifo_q.pop_front();
                        load_pend = 1'b1;
                    end
                end
                if (prev_stall && (!byte_val_o || (byte_dat_o !== prev_dat))) stall_viol++;
                if (byte_val_o && byte_rdy_i) begin
                    cap_q.push_back(byte_dat_o);
                    cap_lst_q.push_back(byte_lst_o);
                    last_hs_cyc = cyc;
                end
                prev_stall = byte_val_o && !byte_rdy_i;
                prev_dat   = byte_dat_o;
                if (adler_val_o && !done_o) stray_aval++;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic run_line(input int w, input int h, input int li, input int typ,
                            input logic [31:0] pix, input bit rnd,
                            input logic [31:0] exp_ad, input int abort_hs);
        logic [31:0] px;
        logic [31:0] ex_ad;
        bit          last;
        bit          seen;
        bit          aborted;
        int          t0;
        last = (li == h - 1);
        if (li == 0) img_q.delete();
        exp_q.delete();
        exp_q.push_back(8'(typ));
        for (int p = 0; p < w; p++) begin
            px = rnd ? $urandom : pix;
            fifo_q.push_back(px);
            exp_q.push_back(px[31:24]);
            exp_q.push_back(px[23:16]);
            exp_q.push_back(px[15:8]);
            exp_q.push_back(px[7:0]);
        end
        foreach (exp_q[i]) img_q.push_back(exp_q[i]);
        rnd_mode = rnd;
        @(posedge clk);
        #1;
        cap_q.delete();
        cap_lst_q.delete();
        rd_empty_viol = 0;
        stall_viol    = 0;
        stray_aval    = 0;
        cfg_w_i   = SIZE_W_WD'(w);
        cfg_h_i   = SIZE_H_WD'(h);
        flt_typ_i = 3'(typ);
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(negedge clk);
        #2;
        check("first_byte_val", byte_val_o, 1'b1);
        check("type_byte", byte_dat_o, 8'(typ));
        t0 = cyc;
        seen = 1'b0;
        aborted = 1'b0;
        for (int k = 0; k < 3000 && !seen && !aborted; k++) begin
            if (abort_hs > 0 && cap_q.size() >= abort_hs) aborted = 1'b1;
            else if (done_o) seen = 1'b1;
            else begin
                @(negedge clk);
                #2;
            end
        end
        if (aborted) begin
            rstn = 1'b0;
            #1;
            chk_reset_vals();
            @(posedge clk);
            @(posedge clk);
            #1;
            fifo_q.delete();
            load_pend = 1'b0;
            rstn = 1'b1;
            rnd_mode = 1'b0;
            return;
        end
`ifdef ADLER32_EN
        ex_ad = (exp_ad != 32'h0) ? exp_ad : ref_adler();
`else
        ex_ad = 32'h0000_0001;
`endif
        check("done_seen", seen, 1'b1);
        check("byte_count", cap_q.size(), exp_q.size());
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("byte[%0d]", i), cap_q[i], exp_q[i]);
            check($sformatf("lst[%0d]", i), cap_lst_q[i], (last && (i == exp_q.size() - 1)));
        end
        check("done_after_last_byte", cyc, last_hs_cyc + 1);
        if (!rnd) check("line_cycles", cyc - t0, 6 * w + 1);
`ifdef ADLER32_EN
        check("adler_val", adler_val_o, last);
`else
        check("adler_val", adler_val_o, 1'b0);
`endif
        if (last) check("adler", adler_o, ex_ad);
        check("rd_while_empty", rd_empty_viol, 0);
        check("stall_stable", stall_viol, 0);
        check("stray_adler_val", stray_aval, 0);
        @(negedge clk);
        #2;
        check("done_pulse", done_o, 1'b0);
        check("adler_val_pulse", adler_val_o, 1'b0);
        if (last) check("adler_hold", adler_o, ex_ad);
        rnd_mode = 1'b0;
    endtask

    initial begin
        rstn      = 1'b1;
        start_i   = 1'b0;
        cfg_w_i   = '0;
        cfg_h_i   = '0;
        flt_typ_i = 3'd0;
        vecs[0] = '{w: 1,  h: 1, typ: 0, pix: 32'h0000_0000, rnd: 1'b0, exp_adler: 32'h0005_0001};
        vecs[1] = '{w: 1,  h: 1, typ: 1, pix: 32'hFFFF_FFFF, rnd: 1'b0, exp_adler: 32'h0A00_03FE};
        vecs[2] = '{w: 64, h: 2, typ: 2, pix: 32'hFFFF_FFFF, rnd: 1'b0, exp_adler: 32'h0};
        vecs[3] = '{w: 4,  h: 1, typ: 4, pix: 32'h0,         rnd: 1'b1, exp_adler: 32'h0};
        vecs[4] = '{w: 0,  h: 1, typ: 3, pix: 32'h0,         rnd: 1'b0, exp_adler: 32'h0004_0004};
        vecs[5] = '{w: 3,  h: 3, typ: 1, pix: 32'h0,         rnd: 1'b1, exp_adler: 32'h0};
        #2;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        rstn = 1'b1;
        @(negedge clk);
        #2;
        chk_reset_vals();

        foreach (vecs[v]) begin
            for (int l = 0; l < vecs[v].h; l++) begin
                run_line(vecs[v].w, vecs[v].h, l, vecs[v].typ, vecs[v].pix,
                         vecs[v].rnd, vecs[v].exp_adler, 0);
            end
        end

        // Line 0 of a two-line image, then reset during the third pixel of line 1.
        run_line(2, 2, 0, 1, 32'hA1B2_C3D4, 1'b0, 32'h0, 0);
        run_line(4, 2, 1, 2, 32'h5566_7788, 1'b0, 32'h0, 11);
        @(negedge clk);
        #2;
        chk_reset_vals();
        // Fresh single-line image: line counter and checksum must have restarted.
        run_line(1, 1, 0, 4, 32'h1234_5678, 1'b0, 32'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
